// File: rtl/pmod_display_pkg.sv
// Items shared between the binary-to-BCD front end and the 7-segment driver.
package pmod_display_pkg;

  localparam int          NUMBER_OF_DIGITS = 8;
  localparam logic [31:0] BCD_MAX          = 32'd99_999_999;
  localparam logic [31:0] OVERFLOW_PATTERN = 32'hEEEE_EEEE;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_display_if.sv
// Upstream value handshake plus the packed-BCD result bus seen by the driver.
interface bin2bcd_display_if #(
  parameter int INPUT_WIDTH = 27
);
  logic [INPUT_WIDTH-1:0] in_value;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            display_data;
  logic                   display_valid;
  logic                   overflow;

  modport master (
    output in_value, in_valid,
    input  in_ready, display_data, display_valid, overflow
  );

  modport slave (
    input  in_value, in_valid,
    output in_ready, display_data, display_valid, overflow
  );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: one BCD nibble, add 3 when it is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Nibble stays 4 bits; a legal BCD digit never carries out here.
  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_display.sv
// Iterative double-dabble converter feeding packed BCD to the display driver.
module bin2bcd_display
  import pmod_display_pkg::*;
#(
  parameter int INPUT_WIDTH = 27
) (
  input logic              clk,
  input logic              rst,
  bin2bcd_display_if.slave bus
);

  localparam int CW = $clog2(INPUT_WIDTH + 1);

  state_t                                 state;
  logic [31:0]                            bcd;
  logic [INPUT_WIDTH-1:0]                 bin;
  logic [CW-1:0]                          cnt;
  logic [NUMBER_OF_DIGITS-1:0][3:0]       adj;
  logic [31:0]                            adj_flat;
  logic [31:0]                            bcd_next;
  logic [31:0]                            in_ext;

  // Per-digit add-3 correction applied to the current scratch nibbles.
  for (genvar g = 0; g < NUMBER_OF_DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .d (bcd[4*g +: 4]),
      .q (adj[g])
    );
  end

  assign adj_flat = adj;
  // Corrected BCD shifted left, pulling in the next binary MSB.
  assign bcd_next = (adj_flat << 1) | 32'(bin[INPUT_WIDTH-1]);
  assign in_ext   = 32'(bus.in_value);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bcd               <= '0;
      bin               <= '0;
      cnt               <= '0;
      bus.display_data  <= '0;
      bus.display_valid <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.in_ready      <= 1'b0;
    end else begin
      bus.display_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            if (in_ext > BCD_MAX) begin
              // Cannot be shown in 8 digits: report at once, stay ready.
              bus.display_data  <= OVERFLOW_PATTERN;
              bus.overflow      <= 1'b1;
              bus.display_valid <= 1'b1;
            end else begin
              bcd          <= '0;
              bin          <= bus.in_value;
              cnt          <= CW'(INPUT_WIDTH);
              state        <= SHIFT;
              bus.in_ready <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          bin <= bin << 1;
          cnt <= cnt - CW'(1);
          // Last iteration: publish only the finished value, never scratch.
          if (cnt == CW'(1)) begin
            bus.display_data  <= bcd_next;
            bus.overflow      <= 1'b0;
            bus.display_valid <= 1'b1;
            bus.in_ready      <= 1'b1;
            state             <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed bench: decimal reference model with per-cycle compare, plus literal checks.
module tb_bin2bcd_display;
  import pmod_display_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_display_if #(.INPUT_WIDTH(27)) b  ();
  bin2bcd_display_if #(.INPUT_WIDTH(4))  b4 ();

  bin2bcd_display #(.INPUT_WIDTH(27)) dut  (.clk(clk), .rst(rst), .bus(b));
  bin2bcd_display #(.INPUT_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [31:0] d;
    logic        ov;
    int          e;
  } res_t;
  res_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r = '0;
    longint      p = 1;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model of the 27-bit block: what the outputs must be each cycle.
  logic [31:0] m_data;
  logic        m_valid, m_ov, m_ready, m_busy;
  int          m_left;
  longint      m_val;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= 0; m_valid <= 0; m_ov <= 0; m_ready <= 0; m_busy <= 0; m_left <= 0; m_val <= 0;
    end else begin
      m_valid <= 0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_data <= to_bcd(m_val); m_ov <= 0; m_valid <= 1; m_ready <= 1; m_busy <= 0;
        end
        m_left <= m_left - 1;
      end else if (m_ready && b.in_valid) begin
        if (longint'(b.in_value) > 99_999_999) begin
          m_data <= 32'hEEEE_EEEE; m_ov <= 1; m_valid <= 1;
        end else begin
          m_val <= longint'(b.in_value); m_left <= 27; m_busy <= 1; m_ready <= 0;
        end
      end else begin
        m_ready <= 1;
      end
    end
  end

  // Per-cycle compare against the model; also collect result pulses.
  initial begin
    forever begin
      @(posedge clk); #2;
      chk("cyc_data",  b.display_data,  m_data);
      chk("cyc_valid", b.display_valid, m_valid);
      chk("cyc_ovf",   b.overflow,      m_ov);
      chk("cyc_ready", b.in_ready,      m_ready);
      if (b.display_valid === 1'b1) q.push_back('{b.display_data, b.overflow, cyc});
    end
  end

  task automatic send(input logic [26:0] v, output int a);
    int n = 0;
    @(negedge clk);
    b.in_value = v; b.in_valid = 1'b1;
    while (b.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1 a = cyc;
  endtask

  task automatic idle();
    @(negedge clk); b.in_valid = 1'b0;
  endtask

  task automatic get(output res_t r);
    int n = 0;
    while (q.size() == 0 && n < 100) begin @(posedge clk); #3; n++; end
    if (q.size() == 0) begin
      chk("result_timeout", 64'(n), 64'd0);
      r = '{32'hx, 1'bx, -1};
    end else r = q.pop_front();
  endtask

  task automatic conv(input logic [26:0] v, input string nm);
    int a; res_t r;
    send(v, a); idle(); get(r);
    chk({nm, "_data"}, r.d, (v > 99_999_999) ? 32'hEEEE_EEEE : to_bcd(v));
    chk({nm, "_ovf"}, r.ov, (v > 99_999_999) ? 1'b1 : 1'b0);
    chk({nm, "_edge"}, 64'(r.e), 64'((v > 99_999_999) ? a : a + 27));
  endtask

  task automatic conv4(input logic [3:0] v);
    int a, n;
    logic got;
    @(negedge clk); b4.in_value = v; b4.in_valid = 1'b1;
    n = 0;
    while (b4.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 a = cyc;
    @(negedge clk); b4.in_valid = 1'b0;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(posedge clk); #2; n++;
      if (b4.display_valid === 1'b1) begin
        got = 1;
        chk("w4_data", b4.display_data, to_bcd(v));
        chk("w4_edge", 64'(cyc), 64'(a + 4));
      end
    end
    if (!got) chk("w4_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int a, a2;
    res_t r;
    b.in_value = '0; b.in_valid = 1'b0;
    b4.in_value = '0; b4.in_valid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_data",  b.display_data, 32'h0);
    chk("rst_ready", b.in_ready, 1'b0);
    chk("rst_valid", b.display_valid, 1'b0);
    chk("rst_ovf",   b.overflow, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    chk("ready_after_rst", b.in_ready, 1'b1);

    // 12345678: result at A+27.
    send(27'd12345678, a); idle(); get(r);
    chk("t1_data", r.d, 32'h1234_5678);
    chk("t1_ovf",  r.ov, 1'b0);
    chk("t1_edge", 64'(r.e), 64'(a + 27));

    // 0 then 99999999 back-to-back.
    send(27'd0, a); send(27'd99_999_999, a2); idle();
    chk("b2b_accept", 64'(a2), 64'(a + 28));
    get(r); chk("b2b_first",  r.d, 32'h0);
    get(r); chk("b2b_second", r.d, 32'h9999_9999);

    // Overflow then 42.
    send(27'd100_000_000, a); idle(); get(r);
    chk("ovf_data",  r.d, 32'hEEEE_EEEE);
    chk("ovf_flag",  r.ov, 1'b1);
    chk("ovf_edge",  64'(r.e), 64'(a));
    chk("ovf_ready", b.in_ready, 1'b1);
    send(27'd42, a); idle(); get(r);
    chk("after_ovf_data", r.d, 32'h0000_0042);
    chk("after_ovf_flag", r.ov, 1'b0);
    chk("after_ovf_edge", 64'(r.e), 64'(a + 27));

    // Back-to-back overflows accepted every cycle.
    send(27'h7FF_FFFF, a); send(27'd100_000_001, a2); idle();
    chk("ovf_b2b_accept", 64'(a2), 64'(a + 1));
    get(r); chk("ovf_b2b_e1", 64'(r.e), 64'(a));
    get(r); chk("ovf_b2b_e2", 64'(r.e), 64'(a2));

    // Assorted values including boundaries.
    conv(27'd1, "v1");
    conv(27'd9, "v9");
    conv(27'd10, "v10");
    conv(27'd65535, "v65535");
    conv(27'd99_999_998, "vmax_m1");
    conv(27'd99_999_999, "vmax");

    // Valid held high with changing value during conversion.
    send(27'd555, a);
    repeat (20) begin @(negedge clk); b.in_value = 27'($urandom_range(0, 99_999_999)); end
    idle(); get(r);
    chk("hold_data", r.d, 32'h0000_0555);
    repeat (40) @(posedge clk);
    #3 chk("hold_extra_pulses", 64'(q.size()), 64'd0);

    // Reset during conversion of 7.
    send(27'd7, a); idle();
    while (cyc < a + 9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_data",  b.display_data, 32'h0);
    chk("midrst_ready", b.in_ready, 1'b0);
    chk("midrst_valid", b.display_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("midrst_ready_back", b.in_ready, 1'b1);
    repeat (30) @(posedge clk);
    #3 chk("midrst_no_pulse", 64'(q.size()), 64'd0);
    send(27'd7, a); idle(); get(r);
    chk("midrst_redo", r.d, 32'h0000_0007);

    // 4-bit instance, all inputs.
    for (int v = 0; v < 16; v++) conv4(4'(v));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
